// File: rtl/stepper_move_sequencer_if.sv
// Move-command handshake bundle for stepper_move_sequencer.
// The command source drives the master side; the sequencer takes the slave side.
interface stepper_move_sequencer_if #(
  parameter int unsigned STEP_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_dir, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_dir, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/stepper_move_sequencer.sv
// Per-axis stepper sequencer: settle, step per tick, position tracking, limit faults.
// Optional homing via STEPPER_HOMING_EN (adds the home_req port and the HOME state).
module stepper_move_sequencer #(
  parameter int unsigned STEP_W       = 16,
  parameter int unsigned POS_W        = 20,
  parameter int unsigned SETTLE_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_tick,
  stepper_move_sequencer_if.slave  cmd,
  input  logic                     abort,
  input  logic [1:0]               limit,
`ifdef STEPPER_HOMING_EN
  input  logic                     home_req,
`endif
  output logic                     motor_en,
  output logic                     motor_dir,
  output logic                     step_pulse,
  output logic                     busy,
  output logic                     done,
  output logic                     fault,
  output logic [POS_W-1:0]         position,
  output logic [STEP_W-1:0]        steps_left
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RUN,
    DONE,
    FAULT
`ifdef STEPPER_HOMING_EN
    , HOME
`endif
  } state_t;

  state_t            state, state_n;
  logic [7:0]        settle_cnt, settle_cnt_n;
  logic              motor_en_n, motor_dir_n, step_pulse_n, busy_n, done_n, fault_n;
  logic [POS_W-1:0]  position_n, position_step;
  logic [STEP_W-1:0] steps_left_n;

  assign cmd.cmd_ready = (state == IDLE);

  assign position_step = motor_dir ? position + POS_W'(1) : position - POS_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      motor_en   <= 1'b0;
      motor_dir  <= 1'b0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      position   <= '0;
      steps_left <= '0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      motor_en   <= motor_en_n;
      motor_dir  <= motor_dir_n;
      step_pulse <= step_pulse_n;
      busy       <= busy_n;
      done       <= done_n;
      fault      <= fault_n;
      position   <= position_n;
      steps_left <= steps_left_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    motor_en_n   = motor_en;
    motor_dir_n  = motor_dir;
    step_pulse_n = 1'b0;
    busy_n       = busy;
    done_n       = 1'b0;
    fault_n      = fault;
    position_n   = position;
    steps_left_n = steps_left;

    unique case (state)
      IDLE: begin
`ifdef STEPPER_HOMING_EN
        if (home_req) begin
          if (limit[0]) begin
            position_n = '0;
            done_n     = 1'b1;
          end else begin
            state_n     = HOME;
            motor_dir_n = 1'b0;
            motor_en_n  = 1'b1;
            busy_n      = 1'b1;
          end
        end else
`endif
        if (cmd.cmd_valid) begin
          if (cmd.cmd_steps == '0) begin
            done_n = 1'b1;
          end else if (limit[cmd.cmd_dir]) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end else begin
            state_n      = SETTLE;
            settle_cnt_n = '0;
            motor_dir_n  = cmd.cmd_dir;
            motor_en_n   = 1'b1;
            busy_n       = 1'b1;
            steps_left_n = cmd.cmd_steps;
          end
        end
      end

      // Limit is checked ahead of step_tick so a coincident tick is dropped.
      SETTLE, RUN: begin
        if (abort) begin
          state_n      = IDLE;
          motor_en_n   = 1'b0;
          busy_n       = 1'b0;
          steps_left_n = '0;
        end else if (limit[motor_dir]) begin
          state_n    = FAULT;
          motor_en_n = 1'b0;
          busy_n     = 1'b0;
          fault_n    = 1'b1;
        end else if (step_tick) begin
          if (state == SETTLE) begin
            if (settle_cnt == 8'(SETTLE_TICKS - 1)) state_n = RUN;
            else settle_cnt_n = settle_cnt + 8'd1;
          end else begin
            step_pulse_n = 1'b1;
            position_n   = position_step;
            steps_left_n = steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state_n    = DONE;
              done_n     = 1'b1;
              motor_en_n = 1'b0;
              busy_n     = 1'b0;
            end
          end
        end
      end

      DONE: state_n = IDLE;

      FAULT: begin
        if (abort) begin
          state_n      = IDLE;
          fault_n      = 1'b0;
          steps_left_n = '0;
        end
      end

`ifdef STEPPER_HOMING_EN
      HOME: begin
        if (abort) begin
          state_n    = IDLE;
          motor_en_n = 1'b0;
          busy_n     = 1'b0;
        end else if (limit[0]) begin
          state_n    = DONE;
          position_n = '0;
          done_n     = 1'b1;
          motor_en_n = 1'b0;
          busy_n     = 1'b0;
        end else if (step_tick) begin
          step_pulse_n = 1'b1;
          position_n   = position_step;
        end
      end
`endif

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Scoreboard bench for stepper_move_sequencer: expected pulses/done events are queued
// when ticks and commands are driven, then matched against the DUT at each negedge.
module tb_stepper_move_sequencer;

  localparam int unsigned STEP_W = 16;
  localparam int unsigned POS_W  = 20;
  localparam int unsigned SETTLE = 4;

  typedef struct {
    int              cyc;
    logic [POS_W-1:0] pos;
    logic            dir;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic step_tick = 1'b0;
  logic abort = 1'b0;
  logic [1:0] limit = 2'b00;
  logic motor_en, motor_dir, step_pulse, busy, done, fault;
  logic [POS_W-1:0] position;
  logic [STEP_W-1:0] steps_left;
`ifdef STEPPER_HOMING_EN
  logic home_req = 1'b0;
`endif

  stepper_move_sequencer_if #(.STEP_W(STEP_W)) cmd_if ();

  stepper_move_sequencer #(
    .STEP_W      (STEP_W),
    .POS_W       (POS_W),
    .SETTLE_TICKS(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_tick (step_tick),
    .cmd       (cmd_if.slave),
    .abort     (abort),
    .limit     (limit),
`ifdef STEPPER_HOMING_EN
    .home_req  (home_req),
`endif
    .motor_en  (motor_en),
    .motor_dir (motor_dir),
    .step_pulse(step_pulse),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .position  (position),
    .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulses = 0;
  int n_exp_pulses = 0;
  bit en_seen = 1'b0;

  ev_t pulse_q[$];
  ev_t done_q[$];

  // Bench reference model: 0 idle, 1 settle, 2 run, 3 home, 4 fault
  int              m_state = 0;
  int              m_cnt = 0;
  int              m_left = 0;
  logic [POS_W-1:0] m_pos = '0;
  logic            m_dir = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (motor_en) en_seen = 1'b1;
    if (step_pulse) begin
      n_pulses++;
      if (pulse_q.size() == 0) check("pulse_spurious", 32'(step_pulse), 32'd0);
      else begin
        e = pulse_q.pop_front();
        check("pulse_cyc", cyc, e.cyc);
        check("pulse_pos", 32'(position), 32'(e.pos));
        check("pulse_dir", 32'(motor_dir), 32'(e.dir));
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_spurious", 32'(done), 32'd0);
      else begin
        e = done_q.pop_front();
        check("done_cyc", cyc, e.cyc);
        check("done_pos", 32'(position), 32'(e.pos));
        check("done_motor_en", 32'(motor_en), 32'd0);
      end
    end
  end

  function automatic void push_pulse(input int c);
    ev_t e;
    m_pos = m_dir ? m_pos + POS_W'(1) : m_pos - POS_W'(1);
    e.cyc = c; e.pos = m_pos; e.dir = m_dir;
    pulse_q.push_back(e);
    n_exp_pulses++;
  endfunction

  function automatic void push_done(input int c);
    ev_t e;
    e.cyc = c; e.pos = m_pos; e.dir = m_dir;
    done_q.push_back(e);
  endfunction

  // The tick is sampled at the next posedge, so its pulse/done appear in cycle cyc+1.
  function automatic void model_tick(input int c);
    case (m_state)
      1: begin
        m_cnt++;
        if (m_cnt == int'(SETTLE)) m_state = 2;
      end
      2: begin
        push_pulse(c);
        m_left--;
        if (m_left == 0) begin
          push_done(c);
          m_state = 0;
        end
      end
      3: push_pulse(c);
      default: ;
    endcase
  endfunction

  task automatic tick(input bit drop, input logic [1:0] lim, input logic ab);
    @(posedge clk); #1;
    step_tick = 1'b1;
    limit = lim;
    abort = ab;
    if (!drop) model_tick(cyc + 1);
    @(posedge clk); #1;
    step_tick = 1'b0;
    abort = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, limit, 1'b0);
  endtask

  task automatic send_cmd(input logic d, input logic [STEP_W-1:0] n);
    @(posedge clk); #1;
    check("cmd_ready_pre", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_steps = n;
    if (n == '0) push_done(cyc + 1);
    else if (limit[d]) m_state = 4;
    else begin
      m_state = 1; m_cnt = 0; m_left = int'(n); m_dir = d;
    end
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic do_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    m_state = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_motor_en", 32'(motor_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_position", 32'(position), 32'd0);
    check("rst_steps_left", 32'(steps_left), 32'd0);
    rst = 1'b1;
    m_state = 0; m_pos = '0; m_dir = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_steps = '0;

    // 1: forward 5 steps
    do_reset();
    send_cmd(1'b1, 16'd5);
    check("t1_motor_en", 32'(motor_en), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_motor_dir", 32'(motor_dir), 32'd1);
    check("t1_steps_left", 32'(steps_left), 32'd5);
    ticks(SETTLE + 5);
    check("t1_position", 32'(position), 32'd5);
    check("t1_steps_left_end", 32'(steps_left), 32'd0);
    check("t1_motor_en_end", 32'(motor_en), 32'd0);

    // 2: reverse 3 steps from 0 wraps to -3
    do_reset();
    send_cmd(1'b0, 16'd3);
    ticks(SETTLE + 3);
    check("t2_position", 32'(position), 32'h000FFFFD);
    check("t2_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);

    // 3: limit[1] lands with the 4th run tick
    send_cmd(1'b1, 16'd10);
    ticks(SETTLE + 3);
    tick(1'b1, 2'b10, 1'b0);
    m_state = 4;
    check("t3_fault", 32'(fault), 32'd1);
    check("t3_steps_left", 32'(steps_left), 32'd7);
    check("t3_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    check("t3_motor_en", 32'(motor_en), 32'd0);
    check("t3_position", 32'(position), 32'(m_pos));
    do_abort();
    check("t3_fault_clr", 32'(fault), 32'd0);
    check("t3_steps_clr", 32'(steps_left), 32'd0);
    check("t3_ready_again", 32'(cmd_if.cmd_ready), 32'd1);

    // 4: limit[1] held; toward it faults at once, away from it runs normally
    send_cmd(1'b1, 16'd5);
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_motor_en", 32'(motor_en), 32'd0);
    check("t4_cmd_ready", 32'(cmd_if.cmd_ready), 32'd0);
    ticks(1);
    do_abort();
    send_cmd(1'b0, 16'd2);
    ticks(SETTLE + 2);
    check("t4_fault_end", 32'(fault), 32'd0);
    check("t4_position", 32'(position), 32'(m_pos));
    limit = 2'b00;

    // 5: abort coincident with a run tick, then a zero-step command
    send_cmd(1'b1, 16'd6);
    ticks(SETTLE + 2);
    tick(1'b1, 2'b00, 1'b1);
    m_state = 0;
    check("t5_cmd_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("t5_motor_en", 32'(motor_en), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_steps_left", 32'(steps_left), 32'd0);
    check("t5_position", 32'(position), 32'(m_pos));
    en_seen = 1'b0;
    send_cmd(1'b0, 16'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_zero_no_en", 32'(en_seen), 32'd0);
    check("t5_zero_ready", 32'(cmd_if.cmd_ready), 32'd1);

`ifdef STEPPER_HOMING_EN
    // 6: homing from +7, limit[0] after 4 ticks
    do_reset();
    send_cmd(1'b1, 16'd7);
    ticks(SETTLE + 7);
    check("t6_start_pos", 32'(position), 32'd7);
    @(posedge clk); #1 home_req = 1'b1;
    m_state = 3; m_dir = 1'b0;
    @(posedge clk); #1 home_req = 1'b0;
    check("t6_motor_dir", 32'(motor_dir), 32'd0);
    check("t6_motor_en", 32'(motor_en), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    ticks(4);
    @(posedge clk); #1 limit = 2'b01;
    m_pos = '0; m_state = 0;
    push_done(cyc + 1);
    @(posedge clk); #1 limit = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("t6_position", 32'(position), 32'd0);
    check("t6_motor_en_end", 32'(motor_en), 32'd0);
    check("t6_fault", 32'(fault), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("pulse_q_drained", pulse_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    check("pulse_total", n_pulses, n_exp_pulses);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
